// File: rtl/ascii_int32_converter.sv
// Converts a stream of ASCII decimal tokens into signed 32-bit integers and
// writes each result into the downstream number buffer at consecutive addresses.
module ascii_int32_converter #(
    parameter int unsigned MAX_NUMS = 2048,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              num_start,
    input  logic [7:0]        num_char,
    input  logic              num_valid,
    input  logic              num_end,
    output logic              result_valid,
    output logic [31:0]       result,
    output logic              result_error,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   num_stored,
    output logic              buf_full,
    output logic              any_error
);

    localparam int unsigned   CNT_W   = ADDR_W + 1;
    localparam logic [35:0]   LIM_POS = 36'h0_7FFF_FFFF;
    localparam logic [35:0]   LIM_NEG = 36'h0_8000_0000;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUMS);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t              r_state;
    logic [31:0]         r_mag;
    logic                r_neg, r_err, r_ovf, r_dig;
    logic                r_result_valid, r_result_error, r_wr_en, r_buf_full, r_any_error;
    logic [31:0]         r_result, r_wr_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [CNT_W-1:0]    r_num_stored;

    logic                w_fresh, w_is_digit;
    logic [3:0]          w_digit;
    logic [31:0]         w_base_mag, w_mag, w_final;
    logic                w_base_neg, w_base_err, w_base_ovf, w_base_dig;
    logic                w_neg, w_err, w_ovf, w_dig, w_final_err;
    logic [35:0]         w_sum, w_limit;
    logic [CNT_W-1:0]    w_stored_nxt;

    // A start strobe opens a fresh token, discarding any open one.
    assign w_fresh    = num_start & num_valid & (r_state != EMIT);
    assign w_base_mag = w_fresh ? 32'd0 : r_mag;
    assign w_base_neg = w_fresh ? 1'b0  : r_neg;
    assign w_base_err = w_fresh ? 1'b0  : r_err;
    assign w_base_ovf = w_fresh ? 1'b0  : r_ovf;
    assign w_base_dig = w_fresh ? 1'b0  : r_dig;

    assign w_is_digit = (num_char >= 8'h30) && (num_char <= 8'h39);
    assign w_digit    = 4'(num_char - 8'h30);
    assign w_sum      = ({4'd0, w_base_mag} << 3) + ({4'd0, w_base_mag} << 1) + 36'(w_digit);
    assign w_limit    = w_base_neg ? LIM_NEG : LIM_POS;

    always_comb begin
        w_mag = w_base_mag;
        w_neg = w_base_neg;
        w_err = w_base_err;
        w_ovf = w_base_ovf;
        w_dig = w_base_dig;
        if (num_valid) begin
            if (num_char == 8'h2D) begin
                if (w_fresh) w_neg = 1'b1;
                else         w_err = 1'b1;
            end else if (w_is_digit) begin
                w_dig = 1'b1;
                if (w_sum > w_limit) begin
                    w_mag = w_limit[31:0];
                    w_ovf = 1'b1;
                end else begin
                    w_mag = w_sum[31:0];
                end
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // Negation of 2^31 wraps to 0x80000000, which is the correct minimum.
    assign w_final      = r_ovf ? (r_neg ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                : (r_neg ? (~r_mag + 32'd1) : r_mag);
    assign w_final_err  = r_err | r_ovf | ~r_dig;
    assign w_stored_nxt = r_num_stored + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mag <= '0; r_neg <= 1'b0; r_err <= 1'b0; r_ovf <= 1'b0; r_dig <= 1'b0;
            r_result_valid <= 1'b0; r_result <= '0; r_result_error <= 1'b0;
            r_wr_en <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0;
            r_num_stored <= '0; r_buf_full <= 1'b0; r_any_error <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_mag <= '0; r_neg <= 1'b0; r_err <= 1'b0; r_ovf <= 1'b0; r_dig <= 1'b0;
            r_result_valid <= 1'b0; r_result <= '0; r_result_error <= 1'b0;
            r_wr_en <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0;
            r_num_stored <= '0; r_buf_full <= 1'b0; r_any_error <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_wr_en        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fresh) begin
                        r_mag <= w_mag; r_neg <= w_neg; r_err <= w_err;
                        r_ovf <= w_ovf; r_dig <= w_dig;
                        r_state <= num_end ? EMIT : ACCUM;
                    end else if (num_end) begin
                        // Empty token: no digits makes it an error with value 0.
                        r_mag <= '0; r_neg <= 1'b0; r_err <= 1'b0;
                        r_ovf <= 1'b0; r_dig <= 1'b0;
                        r_state <= EMIT;
                    end
                end
                ACCUM: begin
                    r_mag <= w_mag; r_neg <= w_neg; r_err <= w_err;
                    r_ovf <= w_ovf; r_dig <= w_dig;
                    if (num_end) r_state <= EMIT;
                end
                EMIT: begin
                    r_result_valid <= 1'b1;
                    r_result       <= w_final;
                    r_result_error <= w_final_err;
                    r_any_error    <= r_any_error | w_final_err | r_buf_full;
                    if (!r_buf_full) begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= r_num_stored[ADDR_W-1:0];
                        r_wr_data    <= w_final;
                        r_num_stored <= w_stored_nxt;
                        r_buf_full   <= (w_stored_nxt == MAX_CNT);
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign result_error = r_result_error;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign num_stored   = r_num_stored;
    assign buf_full     = r_buf_full;
    assign any_error    = r_any_error;

endmodule

// File: tb/tb_ascii_int32_converter.sv
// Directed bench for ascii_int32_converter with a result scoreboard; uses a
// 4-entry buffer so the full-buffer behaviour is reachable.
module tb_ascii_int32_converter;

    localparam int unsigned MAXN = 4;
    localparam int unsigned AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n, clear, num_start, num_valid, num_end;
    logic [7:0]    num_char;
    logic          result_valid, result_error, wr_en, buf_full, any_error;
    logic [31:0]   result, wr_data;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   num_stored;

    ascii_int32_converter #(.MAX_NUMS(MAXN), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .num_start(num_start), .num_char(num_char), .num_valid(num_valid), .num_end(num_end),
        .result_valid(result_valid), .result(result), .result_error(result_error),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_stored(num_stored), .buf_full(buf_full), .any_error(any_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   val;
        logic          err;
        logic          wen;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   m_stored = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every result_valid pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 64'(result_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",       64'(result),       64'(e.val));
                check("result_error", 64'(result_error), 64'(e.err));
                check("latency",      64'(cyc),          64'(e.cyc));
                check("wr_en",        64'(wr_en),        64'(e.wen));
                if (e.wen) begin
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.val));
                end
            end
        end else if (rst_n && wr_en) begin
            check("wr_en_without_result", 64'(wr_en), 64'(0));
        end
    end

    task automatic drive(input logic st, input logic v, input logic [7:0] ch, input logic en);
        @(posedge clk); #1;
        num_start = st; num_valid = v; num_char = ch; num_end = en;
    endtask

    task automatic push_exp(input logic [31:0] val, input logic err);
        exp_t e;
        e.val  = val;
        e.err  = err;
        e.wen  = (m_stored < int'(MAXN));
        e.addr = AW'(m_stored);
        e.cyc  = cyc + 2;
        if (e.wen) m_stored++;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    // Characters on consecutive cycles; end either with the last char or after it.
    task automatic send(input string s, input logic end_with_last,
                        input logic [31:0] val, input logic err);
        for (int i = 0; i < s.len(); i++) begin
            logic last;
            last = end_with_last && (i == s.len() - 1);
            drive(i == 0, 1'b1, s[i], last);
            if (last) push_exp(val, err);
        end
        if (!end_with_last) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            push_exp(val, err);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        wait_drain();
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_stored = 0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_result_valid"}, 64'(result_valid), 64'(0));
        check({tag, "_result"},       64'(result),       64'(0));
        check({tag, "_result_error"}, 64'(result_error), 64'(0));
        check({tag, "_wr_en"},        64'(wr_en),        64'(0));
        check({tag, "_wr_addr"},      64'(wr_addr),      64'(0));
        check({tag, "_wr_data"},      64'(wr_data),      64'(0));
        check({tag, "_num_stored"},   64'(num_stored),   64'(0));
        check({tag, "_buf_full"},     64'(buf_full),     64'(0));
        check({tag, "_any_error"},    64'(any_error),    64'(0));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        num_start = 1'b0; num_valid = 1'b0; num_char = 8'h00; num_end = 1'b0;
        repeat (3) @(posedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic tokens
        send("12", 1'b0, 32'd12, 1'b0);
        send("-34", 1'b0, 32'hFFFF_FFDE, 1'b0);
        send("0", 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        check("t1_num_stored", 64'(num_stored), 64'(3));
        check("t1_any_error",  64'(any_error),  64'(0));
        check("t1_buf_full",   64'(buf_full),   64'(0));

        // Limits and saturation
        do_clear();
        check_all_zero("clear1");
        send("2147483647", 1'b0, 32'h7FFF_FFFF, 1'b0);
        send("-2147483648", 1'b0, 32'h8000_0000, 1'b0);
        @(negedge clk);
        check("t2_any_error_clean", 64'(any_error), 64'(0));
        send("2147483648", 1'b0, 32'h7FFF_FFFF, 1'b1);
        send("-99999999999", 1'b0, 32'h8000_0000, 1'b1);
        @(negedge clk);
        check("t2_any_error", 64'(any_error), 64'(1));

        // Malformed tokens
        do_clear();
        send("1a2", 1'b0, 32'd12, 1'b1);
        send("5-", 1'b0, 32'd5, 1'b1);
        send("-", 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check("t3_num_stored", 64'(num_stored), 64'(3));

        // Buffer fills after four results; the rest still handshake
        do_clear();
        for (int k = 1; k <= 6; k++) begin
            string s;
            s = $sformatf("%0d", k);
            send(s, 1'b1, 32'(k), 1'b0);
            @(negedge clk);
            check("t4_buf_full", 64'(buf_full), 64'(k >= 4));
        end
        check("t4_num_stored", 64'(num_stored), 64'(4));
        check("t4_any_error",  64'(any_error),  64'(1));

        // Clear mid-token drops it; clear beats strobes in the same cycle
        drive(1'b1, 1'b1, "7", 1'b0);
        #1; clear = 1'b1;
        num_start = 1'b0; num_valid = 1'b1; num_char = "8"; num_end = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; m_stored = 0;
        num_valid = 1'b0; num_end = 1'b0;
        repeat (3) check_all_zero("t5_clear");
        send("9", 1'b0, 32'd9, 1'b0);

        // Reset mid-token
        drive(1'b1, 1'b1, "7", 1'b0);
        drive(1'b0, 1'b1, "8", 1'b0);
        rst_n = 1'b0;
        check_all_zero("t5_rst");
        @(posedge clk); #1;
        num_valid = 1'b0;
        rst_n = 1'b1;
        m_stored = 0;
        repeat (3) check_all_zero("t5_after_rst");
        send("9", 1'b0, 32'd9, 1'b0);

        // Restart mid-token, then an end with no open token
        do_clear();
        drive(1'b1, 1'b1, "4", 1'b0);
        drive(1'b0, 1'b1, "5", 1'b0);
        send("6", 1'b0, 32'd6, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        push_exp(32'd0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        wait_drain();
        @(negedge clk);
        check("t6_num_stored", 64'(num_stored), 64'(2));
        check("t6_any_error",  64'(any_error),  64'(1));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascii_int32_converter.md
Name: ascii_int32_converter

Overview:
- Consumes the per-character number stream from the character stream parser (start / char / valid / end strobes).
- Accumulates each decimal token into a signed 32-bit integer, flagging malformed or overflowing tokens.
- Returns a one-cycle result_valid handshake to the parser and writes each result into the downstream number buffer at consecutive addresses.

Parameters:
MAX_NUMS, 2048, capacity of the downstream number buffer (max results stored)
ADDR_W, 11, buffer address width; MAX_NUMS <= 2**ADDR_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous clear, same effect as reset
num_start  in  1  first character of a new token (qualified with num_valid)
num_char  in  8  ASCII character
num_valid  in  1  num_char valid this cycle
num_end  in  1  token complete, one-cycle pulse
result_valid  out  1  one-cycle pulse, conversion done (handshake back to parser)
result  out  32  signed two's-complement value, held until next result_valid
result_error  out  1  token was malformed or saturated; qualifies result
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wr_data  out  32  buffer write data (= result)
num_stored  out  ADDR_W+1  count of results written to buffer
buf_full  out  1  num_stored == MAX_NUMS
any_error  out  1  sticky OR of every result_error and every dropped result since reset/clear

Behaviour:
- Reset or clear: every output is 0; accumulator, sign, digit count and flags are 0; state IDLE. Clear has priority over all strobes in the same cycle.
- States:
  - IDLE -> ACCUM on num_start&num_valid.
  - ACCUM -> EMIT on num_end.
  - EMIT -> IDLE unconditionally after 1 cycle.
  - IDLE -> EMIT on num_end without an open token; result 0, error 1.
- Token restart: num_start&num_valid in ACCUM discards the open token with no output, clears the accumulator, and processes the new char.
- Char processing (num_valid, including the start cycle):
  - '-' (0x2D) as the first char sets neg; '-' anywhere else sets err.
  - '0'..'9': mag = mag*10 + digit, computed single-cycle as (mag<<3)+(mag<<1)+d at 36 bits; digit count increments.
  - Any other char sets err; the accumulator is unchanged.
- Saturation limit: 2147483647 when positive, 2147483648 when neg. If the 36-bit sum exceeds the limit, mag is clamped to the limit, ovf is set, and further digits keep it clamped.
- num_valid and num_end in the same cycle: the char is processed first, then the end is honoured.
- Final value:
  - neg ? -mag : mag.
  - ovf yields 0x7FFFFFFF / 0x80000000 with result_error = 1.
  - Zero digits ("-" alone) yields result 0 with result_error = 1.
  - result_error = err | ovf | no_digits.
- Latency: num_end sampled at edge T -> result_valid, result, result_error and wr_* all registered high for exactly the cycle after edge T+1 (EMIT). Strobes arriving in EMIT are ignored.
- Buffer write:
  - When !buf_full: in EMIT, wr_en = 1, wr_addr = num_stored[ADDR_W-1:0], wr_data = result; num_stored increments at the end of EMIT.
  - Erroneous results are still written.
  - When buf_full: wr_en = 0, result_valid still pulses (parser must not hang), any_error set, num_stored holds at MAX_NUMS.
- Reset or clear mid-token: the token is dropped, no result_valid, and the write pointer returns to 0.
- No back-pressure: the parser guarantees it does not send the next num_start before result_valid.

Test Plan:
1. Stream "12 -34 0" via start/char/end strobes with parser timing -> three result_valid pulses, each 1 cycle after num_end: 12, -34 (0xFFFFFFDE), 0. Writes at wr_addr 0,1,2, error 0, num_stored = 3.
2. Tokens "2147483647", "-2147483648", "2147483648", "-99999999999":
   - first two -> 0x7FFFFFFF and 0x80000000, error 0;
   - third -> 0x7FFFFFFF, error 1;
   - fourth -> 0x80000000, error 1;
   - any_error = 1.
3. Tokens "1a2", "5-", "-" -> all result_error = 1. Values: 12 (invalid char skipped), 5, 0. All three written.
4. MAX_NUMS = 4, six tokens "1".."6":
   - wr_en on the first four only (addr 0..3);
   - buf_full = 1 after the 4th;
   - result_valid pulses all six times;
   - num_stored = 4; any_error = 1.
5. Token "78" interrupted by clear after '7' (and, separately, asserting rst_n low) -> no result_valid, all outputs 0. Next token "9" -> 9 at wr_addr 0.
6. num_start mid-token ("45" then restart with "6") -> only one result, 6, at addr 0. num_end in IDLE with no token -> result 0, result_error 1.
